seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_if.sv | 27 ++
 rtl/seg_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: digit-write and commit handshake bundle for seg_scan_ctrl.
//   wr_valid/wr_ready     write request / accept (accepted when both high)
//   wr_idx, wr_data, wr_on digit index, hex value and visible flag
//   commit                request copy of shadow bank at the next frame boundary
//   commit_pending        commit accepted, copy not yet done
//   frame_done            one-cycle pulse after each copy
// master = host side, slave = seg_scan_ctrl side.
interface seg_scan_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_idx;
  logic [3:0] wr_data;
  logic       wr_on;
  logic       commit;
  logic       commit_pending;
  logic       frame_done;

  modport master (
    output wr_valid, wr_idx, wr_data, wr_on, commit,
    input  wr_ready, commit_pending, frame_done
  );

  modport slave (
    input  wr_valid, wr_idx, wr_data, wr_on, commit,
    output wr_ready, commit_pending, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit multiplexed 7-segment scan controller.
// Each digit slot lasts DIV clk cycles: one blank cycle, then DIV-1 cycles driving
// the digit. Writes land in a shadow bank; a commit copies the whole shadow bank to
// the display bank at the next frame boundary (end of digit 7), so a frame never
// shows a half-updated display.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   bus (slave)      write / commit handshake, see seg_scan_ctrl_if
//   seg[7:0]         {a,b,c,d,e,f,g,dp}, active-low
//   an[7:0]          digit select, active-low, bit n = digit n
//   blink_mask[7:0]  only with SEG_SCAN_BLINK_EN: digits that blink
// Macro SEG_SCAN_BLINK_EN: adds blink_mask and a blink phase toggling every
// BLINK_FRAMES frames; masked digits are blanked while the phase is 1.
module seg_scan_ctrl #(
  parameter int unsigned DIV          = 1000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_ctrl_if.slave    bus,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [7:0]        blink_mask,
`endif
  output logic [7:0]        seg,
  output logic [7:0]        an
);

  // state | meaning
  // BLANK | cnt==0, anodes and segments off (anti-ghosting dead time)
  // SHOW  | cnt 1..DIV-1, digit idx driven from the display bank

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  if (DIV < 2 || DIV > 65535 || BLINK_FRAMES < 1) begin : g_param_check
    $error("seg_scan_ctrl: DIV or BLINK_FRAMES out of range");
  end

  localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [4:0]  shadow [8];
  logic [4:0]  active [8];
  logic        commit_pending;
  logic        frame_done;
  logic        tick;
  logic        boundary;
  logic        digit_hidden;

  assign tick     = (cnt == CNT_LAST);
  assign boundary = tick && (idx == 3'd7);

  function automatic logic [7:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 8'h03;
      4'h1: decode = 8'h9F;
      4'h2: decode = 8'h25;
      4'h3: decode = 8'h0D;
      4'h4: decode = 8'h99;
      4'h5: decode = 8'h49;
      4'h6: decode = 8'h41;
      4'h7: decode = 8'h1F;
      4'h8: decode = 8'h01;
      4'h9: decode = 8'h09;
      4'hA: decode = 8'h11;
      4'hB: decode = 8'hC1;
      4'hC: decode = 8'h63;
      4'hD: decode = 8'h85;
      4'hE: decode = 8'h61;
      default: decode = 8'h71;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= BLANK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    seg       = 8'hFF;
    an        = 8'hFF;
    case (state)
      BLANK: state_nxt = SHOW;
      SHOW: begin
        if (tick) state_nxt = BLANK;
        an = ~(8'h01 << idx);
        if (active[idx][4] && !digit_hidden) seg = decode(active[idx][3:0]);
      end
      default: state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      idx            <= '0;
      commit_pending <= 1'b0;
      frame_done     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      cnt        <= tick ? '0 : cnt + 16'd1;
      if (tick) idx <= idx + 3'd1;
      frame_done <= boundary && commit_pending;
      // A commit arriving on the boundary itself only arms the next boundary.
      if (boundary && commit_pending) begin
        for (int i = 0; i < 8; i++) active[i] <= shadow[i];
        commit_pending <= 1'b0;
      end else if (bus.commit && !commit_pending) begin
        commit_pending <= 1'b1;
      end
      if (bus.wr_valid && !commit_pending) shadow[bus.wr_idx] <= {bus.wr_on, bus.wr_data};
    end
  end

  assign bus.wr_ready       = !commit_pending;
  assign bus.commit_pending = commit_pending;
  assign bus.frame_done     = frame_done;

`ifdef SEG_SCAN_BLINK_EN
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  logic        blink_phase;
  logic [15:0] blink_cnt;
  logic [7:0]  mask_q;

  // mask is registered so seg never depends combinationally on an input
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_phase <= 1'b0;
      blink_cnt   <= '0;
      mask_q      <= '0;
    end else begin
      mask_q <= blink_mask;
      if (boundary) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end

  assign digit_hidden = blink_phase && mask_q[idx];
`else
  assign digit_hidden = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg;
  logic [7:0] an;
  seg_scan_ctrl_if bus();
`ifdef SEG_SCAN_BLINK_EN
  logic [7:0] blink_mask = 8'h00;
`endif

  seg_scan_ctrl #(.DIV(DIV), .BLINK_FRAMES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_shadow [8];
  logic [7:0] exp_q [$];

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 8'h03;  4'h1: seg_of = 8'h9F;  4'h2: seg_of = 8'h25;  4'h3: seg_of = 8'h0D;
      4'h4: seg_of = 8'h99;  4'h5: seg_of = 8'h49;  4'h6: seg_of = 8'h41;  4'h7: seg_of = 8'h1F;
      4'h8: seg_of = 8'h01;  4'h9: seg_of = 8'h09;  4'hA: seg_of = 8'h11;  4'hB: seg_of = 8'hC1;
      4'hC: seg_of = 8'h63;  4'hD: seg_of = 8'h85;  4'hE: seg_of = 8'h61;  default: seg_of = 8'h71;
    endcase
  endfunction

  task automatic push_frame();
    for (int n = 0; n < 8; n++) exp_q.push_back(exp_shadow[n]);
  endtask

  task automatic do_write(input logic [2:0] i, input logic [3:0] d, input logic on);
    int k;
    @(negedge clk);
    bus.wr_idx = i; bus.wr_data = d; bus.wr_on = on; bus.wr_valid = 1'b1;
    for (k = 0; k < 100 && !bus.wr_ready; k++) @(negedge clk);
    checks++;
    if (!bus.wr_ready) begin
      errors++;
      $display("FAIL write_accept idx %0d: wr_ready=%b required 1 within 100 cycles", i, bus.wr_ready);
    end
    @(posedge clk);
    exp_shadow[i] = on ? seg_of(d) : 8'hFF;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge clk);
    bus.commit = 1'b1;
    push_frame();
    @(negedge clk);
    bus.commit = 1'b0;
    checks++;
    if (bus.commit_pending !== 1'b1) begin
      errors++;
      $display("FAIL commit_pending_set: got %b required 1", bus.commit_pending);
    end
  endtask

  task automatic wait_frame_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_done_timeout: no frame_done within 200 cycles");
    end
  endtask

  // Samples the current negedge as frame cycle 'first', then walks to cycle 31.
  task automatic check_frame(input int first);
    logic [7:0] e, exp_an, exp_seg;
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        e = 8'hFF;
        $display("FAIL scoreboard_empty slot %0d: got empty queue required entry", n);
      end else begin
        e = exp_q.pop_front();
      end
      for (int c = 0; c < 4; c++) begin
        if (n * 4 + c >= first) begin
          if (n * 4 + c > first) @(negedge clk);
          exp_an  = (c == 0) ? 8'hFF : ~(8'h01 << n);
          exp_seg = (c == 0) ? 8'hFF : e;
          checks++;
          if (an !== exp_an || seg !== exp_seg) begin
            errors++;
            $display("FAIL frame slot %0d cyc %0d: an=%h seg=%h required an=%h seg=%h",
                     n, c, an, seg, exp_an, exp_seg);
          end
          if (n == 0 && c == 1) begin
            checks++;
            if (bus.frame_done !== 1'b0 || bus.commit_pending !== 1'b0) begin
              errors++;
              $display("FAIL frame_done_pulse: frame_done=%b pending=%b required 0 0",
                       bus.frame_done, bus.commit_pending);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (an !== 8'hFF || seg !== 8'hFF || bus.wr_ready !== 1'b1 ||
        bus.commit_pending !== 1'b0 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: an=%h seg=%h rdy=%b pend=%b fd=%b required FF FF 1 0 0",
               an, seg, bus.wr_ready, bus.commit_pending, bus.frame_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) exp_shadow[i] = 8'hFF;
    @(negedge clk);
    checks++;
    if (an !== 8'hFE || seg !== 8'hFF) begin
      errors++;
      $display("FAIL reset_first_show: an=%h seg=%h required FE FF", an, seg);
    end
  endtask

  task automatic test_single_digit();
    bit ok;
    @(negedge clk);
    bus.wr_idx = 3'd0; bus.wr_data = 4'h3; bus.wr_on = 1'b1;
    bus.wr_valid = 1'b1; bus.commit = 1'b1;
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: wr_ready=%b required 1", bus.wr_ready);
    end
    @(posedge clk);
    exp_shadow[0] = seg_of(4'h3);
    push_frame();
    @(negedge clk);
    bus.wr_valid = 1'b0; bus.commit = 1'b0;
    checks++;
    if (bus.commit_pending !== 1'b1 || bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_pending: pend=%b rdy=%b required 1 0", bus.commit_pending, bus.wr_ready);
    end
    wait_frame_done(ok);
    if (ok) check_frame(0);
  endtask

  task automatic test_all_digits();
    bit ok;
    for (int n = 0; n < 8; n++) do_write(3'(n), 4'(8 + n), 1'b1);
    do_commit();
    wait_frame_done(ok);
    if (ok) check_frame(0);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    do_write(3'd1, 4'h5, 1'b1);
    do_commit();
    bus.wr_idx = 3'd1; bus.wr_data = 4'hA; bus.wr_on = 1'b1; bus.wr_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin ok = 1'b1; break; end
      checks++;
      if (bus.wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready_low: wr_ready=%b required 0 while pending", bus.wr_ready);
      end
    end
    checks++;
    if (!ok || bus.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: frame_done=%b wr_ready=%b required 1 1", ok, bus.wr_ready);
    end
    @(posedge clk);
    exp_shadow[1] = seg_of(4'hA);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    check_frame(1);
    // now at the boundary cycle: commit here must wait one full frame
    bus.commit = 1'b1;
    push_frame();
    @(posedge clk);
    #1 bus.commit = 1'b0;
    checks++;
    if (bus.commit_pending !== 1'b1) begin
      errors++;
      $display("FAIL boundary_commit_pending: got %b required 1", bus.commit_pending);
    end
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.frame_done === 1'b1) break;
    end
    checks++;
    if (n != 32 || bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL boundary_commit_latency: got %0d cycles required 32", n);
    end
    @(negedge clk);
    check_frame(0);
  endtask

  task automatic test_reset_pending();
    do_write(3'd2, 4'h7, 1'b1);
    do_commit();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.commit_pending !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_pending: got %b required 1", bus.commit_pending);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.commit_pending !== 1'b0 || bus.wr_ready !== 1'b1 || an !== 8'hFF ||
        seg !== 8'hFF || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_commit: pend=%b rdy=%b an=%h seg=%h fd=%b required 0 1 FF FF 0",
               bus.commit_pending, bus.wr_ready, an, seg, bus.frame_done);
    end
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_shadow[i] = 8'hFF;
    @(negedge clk);
    checks++;
    if (an !== 8'hFE) begin
      errors++;
      $display("FAIL rst_restart_digit0: an=%h required FE", an);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (bus.frame_done !== 1'b0 || seg !== 8'hFF) begin
        errors++;
        $display("FAIL rst_blank_no_done: cyc %0d fd=%b seg=%h required 0 FF", k, bus.frame_done, seg);
      end
    end
  endtask

`ifdef SEG_SCAN_BLINK_EN
  task automatic test_blink();
    bit ok;
    logic [7:0] s0, s1, s2;
    blink_mask = 8'h01;
    do_write(3'd0, 4'h3, 1'b1);
    do_commit();
    wait_frame_done(ok);
    exp_q.delete();
    @(negedge clk);
    s0 = seg;
    repeat (32) @(negedge clk);
    s1 = seg;
    repeat (32) @(negedge clk);
    s2 = seg;
    checks++;
    if (!((s0 == 8'h0D && s1 == 8'hFF) || (s0 == 8'hFF && s1 == 8'h0D))) begin
      errors++;
      $display("FAIL blink_alternate: got %h then %h required 0D/FF alternating", s0, s1);
    end
    checks++;
    if (s2 !== s0 || an !== 8'hFE) begin
      errors++;
      $display("FAIL blink_period: got %h an=%h required %h an=FE", s2, an, s0);
    end
  endtask
`endif

  initial begin
    bus.wr_valid = 1'b0; bus.wr_idx = '0; bus.wr_data = '0; bus.wr_on = 1'b0; bus.commit = 1'b0;
    test_reset();
    test_single_digit();
    test_all_digits();
    test_back_to_back();
    test_reset_pending();
`ifdef SEG_SCAN_BLINK_EN
    test_blink();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
